// File: rtl/x25519_dh_sequencer.sv
// Runs secret*BASE_POINT then secret*peer on a start/done scalar-multiply core, one request at a time.
// Optional X25519_CLAMP_EN: RFC 7748 clamp of the latched secret (bits[2:0] cleared, bit 254 set).
module x25519_dh_sequencer #(
  parameter logic [254:0] BASE_POINT = 255'd9,
  parameter int unsigned  CYCW       = 20
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [254:0]    req_secret,
  input  logic [254:0]    req_peer,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [254:0]    resp_public,
  output logic [254:0]    resp_shared,
  output logic            resp_error,
  output logic [CYCW-1:0] resp_cycles,
  output logic            core_start,
  output logic [254:0]    core_scalar,
  output logic [254:0]    core_point,
  input  logic            core_done,
  input  logic [254:0]    core_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PUB_START = 3'd1,
    PUB_WAIT  = 3'd2,
    SH_START  = 3'd3,
    SH_WAIT   = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t          state_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic [254:0]    public_q;
  logic [254:0]    shared_q;
  logic            error_q;
  logic [CYCW-1:0] cnt_q;
  logic            core_start_q;
  logic [254:0]    core_scalar_q;
  logic [254:0]    core_point_q;
  logic [254:0]    peer_q;

  logic [254:0]    secret_d;
  logic [CYCW-1:0] cnt_d;

`ifdef X25519_CLAMP_EN
  assign secret_d = {1'b1, req_secret[253:3], 3'b000};
`else
  assign secret_d = req_secret;
`endif

  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CYCW'(1);

  // core_scalar_q doubles as the latched secret: it must stay stable for both operations anyway.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      public_q      <= '0;
      shared_q      <= '0;
      error_q       <= 1'b0;
      cnt_q         <= '0;
      core_start_q  <= 1'b0;
      core_scalar_q <= '0;
      core_point_q  <= '0;
      peer_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q   <= 1'b0;
            core_start_q  <= 1'b1;
            core_scalar_q <= secret_d;
            core_point_q  <= BASE_POINT;
            peer_q        <= req_peer;
            cnt_q         <= CYCW'(1);
            state_q       <= PUB_START;
          end
        end
        PUB_START: begin
          core_start_q <= 1'b0;
          cnt_q        <= cnt_d;
          state_q      <= PUB_WAIT;
        end
        PUB_WAIT: begin
          cnt_q <= cnt_d;
          if (core_done) begin
            public_q     <= core_out;
            core_start_q <= 1'b1;
            core_point_q <= peer_q;
            state_q      <= SH_START;
          end
        end
        SH_START: begin
          core_start_q <= 1'b0;
          cnt_q        <= cnt_d;
          state_q      <= SH_WAIT;
        end
        SH_WAIT: begin
          cnt_q <= cnt_d;
          if (core_done) begin
            shared_q     <= core_out;
            error_q      <= (core_out == '0);
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          req_ready_q  <= 1'b0;
          core_start_q <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_public = public_q;
  assign resp_shared = shared_q;
  assign resp_error  = error_q;
  assign resp_cycles = cnt_q;
  assign core_start  = core_start_q;
  assign core_scalar = core_scalar_q;
  assign core_point  = core_point_q;

  a_start_single: assert property (@(posedge clock) disable iff (!reset_n)
    core_start_q |=> !core_start_q);

endmodule

// File: tb/tb_x25519_dh_sequencer.sv
// Bench for x25519_dh_sequencer: mock cores (out = scalar ^ point, done D cycles after start) and a spec-level model.
module tb_x25519_dh_sequencer;
  localparam logic [254:0] BP = 255'd9;

  int checks = 0;
  int failures = 0;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic         req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, resp_error;
  logic [254:0] req_secret = '0, req_peer = '0, resp_public, resp_shared;
  logic [19:0]  resp_cycles;
  logic         core_start, core_done;
  logic [254:0] core_scalar, core_point, core_out;

  logic         s_req_valid = 1'b0, s_req_ready, s_resp_valid, s_resp_ready = 1'b0, s_resp_error;
  logic [254:0] s_req_secret = '0, s_req_peer = '0, s_resp_public, s_resp_shared;
  logic [3:0]   s_resp_cycles;
  logic         s_core_start, s_core_done;
  logic [254:0] s_core_scalar, s_core_point, s_core_out;

  x25519_dh_sequencer #(.BASE_POINT(BP), .CYCW(20)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_secret(req_secret), .req_peer(req_peer),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_public(resp_public),
    .resp_shared(resp_shared), .resp_error(resp_error), .resp_cycles(resp_cycles),
    .core_start(core_start), .core_scalar(core_scalar), .core_point(core_point),
    .core_done(core_done), .core_out(core_out)
  );

  x25519_dh_sequencer #(.BASE_POINT(BP), .CYCW(4)) u_sat (
    .clock(clock), .reset_n(reset_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_secret(s_req_secret), .req_peer(s_req_peer),
    .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_public(s_resp_public),
    .resp_shared(s_resp_shared), .resp_error(s_resp_error), .resp_cycles(s_resp_cycles),
    .core_start(s_core_start), .core_scalar(s_core_scalar), .core_point(s_core_point),
    .core_done(s_core_done), .core_out(s_core_out)
  );

  // Mock cores ignore reset on purpose: a late done after a sequencer reset must be harmless.
  int mock_d = 3;
  int m_cnt = 0;
  logic m_busy = 1'b0, m_done = 1'b0;
  logic [254:0] m_out = '0;
  assign core_done = m_done;
  assign core_out  = m_out;
  always @(posedge clock) begin
    if (core_start) begin
      m_out <= core_scalar ^ core_point;
      if (mock_d <= 1) begin m_done <= 1'b1; m_busy <= 1'b0; end
      else begin m_done <= 1'b0; m_busy <= 1'b1; m_cnt <= 1; end
    end else if (m_busy) begin
      if (m_cnt == mock_d - 1) begin m_done <= 1'b1; m_busy <= 1'b0; end
      m_cnt <= m_cnt + 1;
    end
  end

  localparam int SAT_D = 16;
  int s_cnt = 0;
  logic s_busy = 1'b0, s_done = 1'b0;
  logic [254:0] s_out = '0;
  assign s_core_done = s_done;
  assign s_core_out  = s_out;
  always @(posedge clock) begin
    if (s_core_start) begin
      s_out <= s_core_scalar ^ s_core_point;
      s_done <= 1'b0; s_busy <= 1'b1; s_cnt <= 1;
    end else if (s_busy) begin
      if (s_cnt == SAT_D - 1) begin s_done <= 1'b1; s_busy <= 1'b0; end
      s_cnt <= s_cnt + 1;
    end
  end

  function automatic logic [254:0] m_clamp(input logic [254:0] s);
`ifdef X25519_CLAMP_EN
    return (s & ~255'h7) | (255'd1 << 254);
`else
    return s;
`endif
  endfunction

  function automatic logic [254:0] rand255();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[254:0];
  endfunction

  function automatic int exp_cycles(input int lat, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (lat > mx) ? mx : lat;
  endfunction

  // Called at a negedge; returns at the negedge where resp_valid is first seen (relative cycle lat).
  task automatic drive_txn(input logic [254:0] s, input logic [254:0] p, output int lat,
                           output int st0, output int st1, output logic [254:0] sc0, output bit tmo);
    int k, nst;
    tmo = 1'b0; lat = -1; st0 = -1; st1 = -1; nst = 0; sc0 = '0; k = 0;
    while (!req_ready && k < 50) begin @(negedge clock); k++; end
    if (!req_ready) begin tmo = 1'b1; return; end
    req_valid = 1'b1; req_secret = s; req_peer = p;
    @(negedge clock);
    req_valid = 1'b0; req_secret = rand255(); req_peer = rand255();
    for (k = 1; k < 200; k++) begin
      if (core_start) begin
        if (nst == 0) begin st0 = k; sc0 = core_scalar; end
        else if (nst == 1) st1 = k;
        nst++;
      end
      if (resp_valid) begin lat = k; break; end
      @(negedge clock);
    end
    if (lat < 0) tmo = 1'b1;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic check_result(input string nm, input logic [254:0] s, input logic [254:0] p,
                              input int d, input int lat, input bit tmo);
    logic [254:0] e_pub, e_sh;
    e_pub = m_clamp(s) ^ BP;
    e_sh  = m_clamp(s) ^ p;
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL %s_timeout got=%0d want=0", nm, tmo); end
    checks++; if (lat != 2*d + 3) begin failures++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, 2*d+3); end
    checks++; if (resp_public !== e_pub) begin failures++; $display("FAIL %s_public got=%h want=%h", nm, resp_public, e_pub); end
    checks++; if (resp_shared !== e_sh) begin failures++; $display("FAIL %s_shared got=%h want=%h", nm, resp_shared, e_sh); end
    checks++; if (resp_error !== (e_sh == '0)) begin failures++; $display("FAIL %s_error got=%0d want=%0d", nm, resp_error, (e_sh == '0)); end
    checks++; if (int'(resp_cycles) != exp_cycles(2*d+3, 20)) begin failures++; $display("FAIL %s_cycles got=%0d want=%0d", nm, resp_cycles, exp_cycles(2*d+3, 20)); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({req_ready, resp_valid, resp_public, resp_shared, resp_error, resp_cycles, core_start, core_scalar, core_point} !== '0) begin
      failures++; $display("FAIL reset_outputs got rdy=%0d vld=%0d start=%0d cyc=%0d want all zero", req_ready, resp_valid, core_start, resp_cycles);
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0d want=1", req_ready); end
    checks++; if (s_req_ready !== 1'b1) begin failures++; $display("FAIL reset_sat_req_ready got=%0d want=1", s_req_ready); end
  endtask

  task automatic test_basic();
    int lat, st0, st1; logic [254:0] sc0; bit tmo;
    mock_d = 3;
    drive_txn(255'h1234, 255'h55, lat, st0, st1, sc0, tmo);
    checks++; if (st0 != 1) begin failures++; $display("FAIL basic_start0 got=%0d want=1", st0); end
    checks++; if (st1 != 5) begin failures++; $display("FAIL basic_start1 got=%0d want=5", st1); end
    check_result("basic", 255'h1234, 255'h55, 3, lat, tmo);
    finish_resp();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL basic_release got vld=%0d rdy=%0d want vld=0 rdy=1", resp_valid, req_ready); end
  endtask

  task automatic test_low_order();
    int lat, st0, st1; logic [254:0] sc0, s; bit tmo;
    mock_d = 3;
    drive_txn(255'h55, 255'h55, lat, st0, st1, sc0, tmo);
    check_result("low55", 255'h55, 255'h55, 3, lat, tmo);
    finish_resp();
    s = rand255();
    drive_txn(s, m_clamp(s), lat, st0, st1, sc0, tmo);
    checks++; if (resp_error !== 1'b1) begin failures++; $display("FAIL low_rand_error got=%0d want=1", resp_error); end
    check_result("low_rand", s, m_clamp(s), 3, lat, tmo);
    finish_resp();
  endtask

  task automatic test_clamp();
    int lat, st0, st1; logic [254:0] sc0, e_sc; bit tmo;
`ifdef X25519_CLAMP_EN
    e_sc = {1'b1, 246'd0, 8'hF8};
`else
    e_sc = 255'hFF;
`endif
    mock_d = 3;
    drive_txn(255'hFF, 255'h0, lat, st0, st1, sc0, tmo);
    checks++; if (sc0 !== e_sc) begin failures++; $display("FAIL clamp_scalar got=%h want=%h", sc0, e_sc); end
    check_result("clamp", 255'hFF, 255'h0, 3, lat, tmo);
    finish_resp();
  endtask

  task automatic test_backpressure();
    int lat, st0, st1; logic [254:0] sc0, s1, p1, s2, p2, h_pub, h_sh; logic h_err; logic [19:0] h_cyc; bit tmo;
    mock_d = 4;
    s1 = rand255(); p1 = rand255(); s2 = rand255(); p2 = rand255();
    drive_txn(s1, p1, lat, st0, st1, sc0, tmo);
    check_result("bp1", s1, p1, 4, lat, tmo);
    h_pub = resp_public; h_sh = resp_shared; h_err = resp_error; h_cyc = resp_cycles;
    req_valid = 1'b1; req_secret = s2; req_peer = p2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (resp_valid !== 1'b1 || resp_public !== h_pub || resp_shared !== h_sh || resp_error !== h_err || resp_cycles !== h_cyc) begin
        failures++; $display("FAIL bp_stable_%0d got vld=%0d cyc=%0d want vld=1 cyc=%0d unchanged", i, resp_valid, resp_cycles, h_cyc);
      end
      checks++;
      if (req_ready !== 1'b0 || core_start !== 1'b0) begin
        failures++; $display("FAIL bp_no_accept_%0d got rdy=%0d start=%0d want 0 0", i, req_ready, core_start);
      end
    end
    finish_resp();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_release got vld=%0d rdy=%0d want vld=0 rdy=1", resp_valid, req_ready); end
    drive_txn(s2, p2, lat, st0, st1, sc0, tmo);
    checks++; if (st0 != 1) begin failures++; $display("FAIL bp2_start0 got=%0d want=1", st0); end
    check_result("bp2", s2, p2, 4, lat, tmo);
    finish_resp();
  endtask

  task automatic test_back_to_back();
    int lat, st0, st1; logic [254:0] sc0, s, p; bit tmo;
    resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mock_d = 1 + i;
      s = rand255(); p = rand255();
      drive_txn(s, p, lat, st0, st1, sc0, tmo);
      check_result("b2b", s, p, mock_d, lat, tmo);
      @(negedge clock);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL b2b_same_cycle got vld=%0d rdy=%0d want vld=0 rdy=1", resp_valid, req_ready); end
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int lat, st0, st1; logic [254:0] sc0, s, p; bit tmo;
    mock_d = 3;
    req_valid = 1'b1; req_secret = rand255(); req_peer = rand255();
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_public, resp_shared, resp_error, resp_cycles, core_start, core_scalar, core_point} !== '0) begin
      failures++; $display("FAIL midreset_async got rdy=%0d start=%0d cyc=%0d scalar=%h want all zero", req_ready, core_start, resp_cycles, core_scalar);
    end
    #1 reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b0 || core_start !== 1'b0) begin failures++; $display("FAIL midreset_ignore_done_%0d got vld=%0d start=%0d want 0 0", i, resp_valid, core_start); end
      @(negedge clock);
    end
    s = rand255(); p = rand255();
    drive_txn(s, p, lat, st0, st1, sc0, tmo);
    check_result("midreset_new", s, p, 3, lat, tmo);
    finish_resp();
  endtask

  task automatic test_random();
    int lat, st0, st1, d, hold; logic [254:0] sc0, s, p; bit tmo;
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(1, 6); hold = $urandom_range(0, 3);
      mock_d = d; s = rand255(); p = rand255();
      drive_txn(s, p, lat, st0, st1, sc0, tmo);
      check_result("rand", s, p, d, lat, tmo);
      checks++; if (st1 != d + 2) begin failures++; $display("FAIL rand_start1 got=%0d want=%0d", st1, d + 2); end
      repeat (hold) @(negedge clock);
      checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL rand_hold got=%0d want=1", resp_valid); end
      finish_resp();
    end
  endtask

  task automatic test_saturate();
    int k; logic [254:0] s, p;
    s = rand255(); p = rand255();
    checks++; if (s_req_ready !== 1'b1) begin failures++; $display("FAIL sat_req_ready got=%0d want=1", s_req_ready); end
    s_req_valid = 1'b1; s_req_secret = s; s_req_peer = p;
    @(negedge clock);
    s_req_valid = 1'b0; k = 1;
    while (!s_resp_valid && k < 100) begin @(negedge clock); k++; end
    checks++; if (k != 2*SAT_D + 3) begin failures++; $display("FAIL sat_latency got=%0d want=%0d", k, 2*SAT_D + 3); end
    checks++; if (int'(s_resp_cycles) != exp_cycles(2*SAT_D + 3, 4)) begin failures++; $display("FAIL sat_cycles got=%0d want=%0d", s_resp_cycles, exp_cycles(2*SAT_D + 3, 4)); end
    checks++; if (s_resp_shared !== (m_clamp(s) ^ p)) begin failures++; $display("FAIL sat_shared got=%h want=%h", s_resp_shared, m_clamp(s) ^ p); end
    s_resp_ready = 1'b1;
    @(negedge clock);
    s_resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_low_order();
    test_clamp();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/x25519_dh_sequencer.md
Name: x25519_dh_sequencer

Overview:
- Initiator-side controller for the curve25519 scalar-multiply core's start/done interface.
- Takes one request (secret, peer public point) and runs two back-to-back core operations:
  - public = secret·BASE_POINT
  - shared = secret·peer
- Returns both results through a valid/ready response, with a low-order (all-zero shared) error flag and a latency count.
- Replaces hand-sequenced bench/firmware driving of the core.

Parameters:
- BASE_POINT, 255'd9, u-coordinate used for the public-key operation.
- CYCW, 20, width of the latency counter `resp_cycles`.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_secret  in  255  private scalar.
- req_peer  in  255  peer public u-coordinate.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_public  out  255  secret·BASE_POINT.
- resp_shared  out  255  secret·peer.
- resp_error  out  1  resp_shared is all-zero.
- resp_cycles  out  CYCW  cycles from request accept to resp_valid rise, saturating.
- core_start  out  1  one-cycle start pulse to the core.
- core_scalar  out  255  scalar to the core.
- core_point  out  255  point to the core.
- core_done  in  1  core result ready.
- core_out  in  255  core result.

Behaviour:
- Reset (asynchronous, reset_n low) forces:
  - state IDLE;
  - all outputs 0, except req_ready = 1 once reset deasserts;
  - all internal registers 0.
- Reset mid-operation abandons the operation. The core restarts on any later core_start, so no core flush is needed.
- States: IDLE, PUB_START, PUB_WAIT, SH_START, SH_WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch req_secret (clamped if enabled) and req_peer, clear the counter, go to PUB_START.
- PUB_START:
  - core_start = 1, core_scalar = secret, core_point = BASE_POINT.
  - Go to PUB_WAIT.
- PUB_WAIT:
  - core_start = 0; core_scalar/core_point held.
  - On core_done = 1: latch core_out into public, go to SH_START.
- SH_START:
  - core_start = 1, core_scalar = secret, core_point = peer.
  - Go to SH_WAIT.
- SH_WAIT:
  - On core_done = 1: latch core_out into shared; resp_error = (core_out == 0). Go to RESP.
- RESP:
  - resp_valid = 1; all resp_* outputs stable until handshake.
  - On resp_ready: go to IDLE; resp_valid drops and req_ready rises the next cycle.
  - resp_ready asserted in the same cycle resp_valid rises completes in one cycle.
- Core contract:
  - The core drops core_done on the edge that samples core_start, so WAIT states never see a stale done.
  - core_done is ignored in all states other than PUB_WAIT and SH_WAIT.
  - core_start is never high in two consecutive cycles.
  - core_scalar/core_point are stable from the start cycle through the done cycle.
- Counter:
  - Increments every cycle from the accept cycle (counted as 0) until resp_valid rises.
  - Saturates at 2^CYCW−1; frozen in RESP.
- Latency: if the core raises done D cycles after each start cycle, resp_valid rises 2D+3 cycles after the accept cycle.
- req_valid while not in IDLE is ignored (req_ready = 0). Only one request is in flight at a time.

Optional Feature:
- Macro X25519_CLAMP_EN.
- Defined: the latched secret is RFC 7748 clamped — bits[2:0] cleared, bit 254 set, all other bits unchanged.
- Undefined: secret is passed to the core verbatim.

Test Plan:
All cases use a mock core with done D = 3 cycles after start and core_out = core_scalar ^ core_point.
1. Reset, then secret = 0x1234, peer = 0x55, clamp off:
   - core_start high in cycles 1 and 5;
   - resp_valid rises in cycle 9;
   - resp_public = 0x1234^9 = 0x123D, resp_shared = 0x1234^0x55 = 0x1261;
   - resp_cycles = 9, resp_error = 0.
2. secret = 0x55, peer = 0x55:
   - resp_shared = 0, resp_error = 1.
3. With X25519_CLAMP_EN, secret = 0xFF, peer = 0:
   - core_scalar = (1<<254)|0xF8;
   - resp_shared = (1<<254)|0xF8;
   - resp_public = (1<<254)|0xF1.
4. resp_ready held low for 5 cycles:
   - resp_* stable throughout;
   - second req_valid with different data not accepted until the cycle after resp_ready;
   - second result correct.
5. reset_n pulsed low during PUB_WAIT:
   - outputs 0 immediately (asynchronous);
   - mock's late core_done ignored;
   - a new request completes with correct values and resp_cycles = 9.
6. Mock with D = 2^CYCW (CYCW overridden to 4):
   - resp_cycles saturates at 15.
